i2s_tx_feeder: RTL

Upstream companion of the I2S serializer: runs in the system clock domain, generates the bit clock (SCLK) and word-select clock (LRCK) for the I2S link, and presents a stable left/right parallel sample pair to the serializer. Stereo samples arrive over a valid/ready stream, are buffered in a small FIFO, and are transferred to the output holding registers once per frame at a point where the serializer is not sampling them. Underruns mute the frame and are reported.

---
 rtl/i2s_tx_feeder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/i2s_tx_feeder.sv
// I2S transmit feeder: generates SCLK/LRCK from the system clock, buffers stereo
// pairs in a small FIFO and reloads the serializer's holding pair mid-left-word.
module i2s_tx_feeder #(
  parameter int PDATA_WIDTH = 32,
  parameter int SCLK_DIV    = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           en_in,
  input  logic [PDATA_WIDTH-1:0]         s_ldata_in,
  input  logic [PDATA_WIDTH-1:0]         s_rdata_in,
  input  logic                           s_valid_in,
  output logic                           s_ready_out,
  output logic                           sclk_out,
  output logic                           lrck_out,
  output logic [PDATA_WIDTH-1:0]         pldata_out,
  output logic [PDATA_WIDTH-1:0]         prdata_out,
  output logic                           underrun_out,
  output logic [15:0]                    underrun_cnt_out,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level_out
);

  localparam int DW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(2 * PDATA_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  // Stream handshake: a pair is accepted at a clk_in rising edge when
  // s_valid_in and s_ready_out are both high; s_ready_out is a registered
  // function of the FIFO level and never depends on s_valid_in.

  logic          run_q;
  logic [DW-1:0] dcnt;
  logic [BW-1:0] bcnt;
  logic [DW-1:0] dcnt_nxt;
  logic [BW-1:0] bcnt_nxt;
  logic          active;
  logic          dwrap;
  logic          pop_pt;

  // run_q makes the first enabled edge a restart edge (dcnt=0, bcnt=0),
  // so every frame begins cleanly with SCLK low in its first half-period.
  assign active = en_in & run_q;
  assign dwrap  = active && (dcnt == DW'(SCLK_DIV - 1));
  assign pop_pt = dwrap && (bcnt == BW'(PDATA_WIDTH / 2 - 1));

  always_comb begin
    dcnt_nxt = '0;
    bcnt_nxt = '0;
    if (active) begin
      dcnt_nxt = dwrap ? '0 : dcnt + 1'b1;
      bcnt_nxt = bcnt;
      if (dwrap) begin
        bcnt_nxt = (bcnt == BW'(2 * PDATA_WIDTH - 1)) ? '0 : bcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      run_q    <= 1'b0;
      dcnt     <= '0;
      bcnt     <= '0;
      sclk_out <= 1'b0;
      lrck_out <= 1'b0;
    end else begin
      run_q    <= en_in;
      dcnt     <= dcnt_nxt;
      bcnt     <= bcnt_nxt;
      sclk_out <= (dcnt_nxt >= DW'(SCLK_DIV / 2));
      lrck_out <= (bcnt_nxt >= BW'(PDATA_WIDTH));
    end
  end

  logic [2*PDATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [LW-1:0]            level;
  logic [LW-1:0]            level_nxt;
  logic                     push;
  logic                     pop;
  logic                     empty_pop;

  assign push      = s_valid_in & s_ready_out;
  assign pop       = pop_pt && (level != '0);
  assign empty_pop = pop_pt && (level == '0);

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + 1'b1;
    end else if (pop && !push) begin
      level_nxt = level - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= {s_ldata_in, s_rdata_in};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      s_ready_out <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level       <= level_nxt;
      s_ready_out <= (level_nxt < LW'(FIFO_DEPTH));
    end
  end

  assign fifo_level_out = level;

  // Holding pair changes only mid-left-word, away from both LRCK edges.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pldata_out       <= '0;
      prdata_out       <= '0;
      underrun_out     <= 1'b0;
      underrun_cnt_out <= '0;
    end else begin
      underrun_out <= empty_pop;
      if (pop) begin
        pldata_out <= mem[rd_ptr][2*PDATA_WIDTH-1:PDATA_WIDTH];
        prdata_out <= mem[rd_ptr][PDATA_WIDTH-1:0];
      end else if (empty_pop) begin
        pldata_out <= '0;
        prdata_out <= '0;
      end
      if (empty_pop && (underrun_cnt_out != 16'hFFFF)) begin
        underrun_cnt_out <= underrun_cnt_out + 16'd1;
      end
    end
  end

endmodule
